// File: rtl/vga_pattern_cmd.sv
// UART command parser that selects the VGA test pattern.
// A command is 'P'/'p', one hex digit, then CR. It applies on the next VSync rising edge.
module vga_pattern_cmd #(
   parameter logic [3:0]  DEFAULT_PATTERN = 4'h4,
   parameter int unsigned TIMEOUT_CLKS    = 25_000_000
) (
   input  logic       i_Clk,
   input  logic       i_Rst_L,
   input  logic       i_RX_DV,
   input  logic [7:0] i_RX_Byte,
   input  logic       i_VSync,
   input  logic       i_TX_Active,
   output logic [3:0] o_Pattern,
   output logic       o_Pending,
   output logic       o_TX_DV,
   output logic [7:0] o_TX_Byte
);

   localparam int unsigned      CNT_W    = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_GOT_P     = 2'd1;
   localparam logic [1:0] ST_GOT_DIGIT = 2'd2;

   localparam logic [7:0] CHAR_CR   = 8'h0D;
   localparam logic [7:0] CHAR_OK   = 8'h4B;
   localparam logic [7:0] CHAR_ERR  = 8'h3F;

   logic [1:0]       state_q, state_d;
   logic [3:0]       digit_q, digit_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       pattern_q;
   logic [3:0]       pend_val_q;
   logic             pend_q;
   logic             vsync_q;
   logic             reply_full_q;
   logic [7:0]       reply_byte_q;
   logic [7:0]       tx_byte_q;

   logic             is_hex;
   logic [3:0]       hex_val;
   logic             accept;
   logic             reply_set;
   logic [7:0]       reply_val;
   logic             frame;
   logic             tx_fire;

   // Letters A-F and a-f share low nibbles 1-6.
   always_comb begin
      is_hex  = 1'b1;
      hex_val = 4'h0;
      if (i_RX_Byte >= 8'h30 && i_RX_Byte <= 8'h39) begin
         hex_val = i_RX_Byte[3:0];
      end else if ((i_RX_Byte >= 8'h41 && i_RX_Byte <= 8'h46) ||
                   (i_RX_Byte >= 8'h61 && i_RX_Byte <= 8'h66)) begin
         hex_val = i_RX_Byte[3:0] + 4'd9;
      end else begin
         is_hex = 1'b0;
      end
   end

   always_comb begin
      state_d   = state_q;
      digit_d   = digit_q;
      cnt_d     = cnt_q;
      accept    = 1'b0;
      reply_set = 1'b0;
      reply_val = CHAR_ERR;
      if (i_RX_DV) begin
         cnt_d = '0;
         case (state_q)
            ST_IDLE: begin
               if (i_RX_Byte == 8'h50 || i_RX_Byte == 8'h70) state_d = ST_GOT_P;
            end
            ST_GOT_P: begin
               if (is_hex) begin
                  digit_d = hex_val;
                  state_d = ST_GOT_DIGIT;
               end else begin
                  reply_set = 1'b1;
                  state_d   = ST_IDLE;
               end
            end
            ST_GOT_DIGIT: begin
               reply_set = 1'b1;
               state_d   = ST_IDLE;
               if (i_RX_Byte == CHAR_CR) begin
                  accept    = 1'b1;
                  reply_val = CHAR_OK;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end else if (state_q == ST_IDLE) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         // Abandon a stalled command without replying.
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign frame   = i_VSync & ~vsync_q;
   assign tx_fire = reply_full_q & ~i_TX_Active;

   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         state_q      <= ST_IDLE;
         digit_q      <= 4'h0;
         cnt_q        <= '0;
         pattern_q    <= DEFAULT_PATTERN;
         pend_val_q   <= 4'h0;
         pend_q       <= 1'b0;
         vsync_q      <= 1'b1;
         reply_full_q <= 1'b0;
         reply_byte_q <= 8'h00;
         tx_byte_q    <= 8'h00;
      end else begin
         state_q <= state_d;
         digit_q <= digit_d;
         cnt_q   <= cnt_d;
         vsync_q <= i_VSync;
         if (frame && pend_q) begin
            pattern_q <= pend_val_q;
            pend_q    <= 1'b0;
         end
         // A CR on the boundary cycle re-arms pending after the older value applies.
         if (accept) begin
            pend_q     <= 1'b1;
            pend_val_q <= digit_q;
         end
         if (tx_fire) begin
            reply_full_q <= 1'b0;
            tx_byte_q    <= reply_byte_q;
         end
         if (reply_set) begin
            reply_full_q <= 1'b1;
            reply_byte_q <= reply_val;
         end
      end
   end

   assign o_Pattern = pattern_q;
   assign o_Pending = pend_q;
   assign o_TX_DV   = tx_fire;
   assign o_TX_Byte = tx_fire ? reply_byte_q : tx_byte_q;

endmodule

// File: tb/tb_vga_pattern_cmd.sv
// Directed bench for vga_pattern_cmd; a monitor checks every reply strobe against a queue
// of expected reply bytes filled by the stimulus.
module tb_vga_pattern_cmd;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx_dv;
   logic [7:0] rx_byte;
   logic       vsync;
   logic       tx_active;
   logic [3:0] pattern;
   logic       pending;
   logic       tx_dv;
   logic [7:0] tx_byte;

   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] exp_q[$];

   vga_pattern_cmd #(
      .DEFAULT_PATTERN(4'h4),
      .TIMEOUT_CLKS   (16)
   ) dut (
      .i_Clk      (clk),
      .i_Rst_L    (rst_n),
      .i_RX_DV    (rx_dv),
      .i_RX_Byte  (rx_byte),
      .i_VSync    (vsync),
      .i_TX_Active(tx_active),
      .o_Pattern  (pattern),
      .o_Pending  (pending),
      .o_TX_DV    (tx_dv),
      .o_TX_Byte  (tx_byte)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send(input logic [7:0] b);
      rx_dv   = 1'b1;
      rx_byte = b;
      tick();
      rx_dv   = 1'b0;
      rx_byte = 8'h00;
   endtask

   task automatic cmd(input logic [7:0] p, input logic [7:0] d);
      send(p);
      send(d);
      exp_q.push_back(8'h4B);
      send(8'h0D);
   endtask

   task automatic frame(input string nm, input logic [3:0] pre, input logic [3:0] post);
      vsync = 1'b1;
      chk({nm, "_pre"}, 8'(pattern), 8'(pre));
      tick();
      chk({nm, "_post"}, 8'(pattern), 8'(post));
      chk({nm, "_pend_clr"}, 8'(pending), 8'h00);
      vsync = 1'b0;
      tick();
   endtask

   // Reply monitor.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && tx_dv === 1'b1) begin
         chk("strobe_tx_idle", 8'(tx_active), 8'h00);
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_reply: got %h, expected no strobe", tx_byte);
         end else begin
            chk("reply_byte", tx_byte, exp_q.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      rx_dv     = 1'b0;
      rx_byte   = 8'h00;
      vsync     = 1'b0;
      tx_active = 1'b0;
      ticks(3);
      chk("rst_pattern", 8'(pattern), 8'h04);
      chk("rst_pending", 8'(pending), 8'h00);
      chk("rst_tx_dv", 8'(tx_dv), 8'h00);
      chk("rst_tx_byte", tx_byte, 8'h00);
      rst_n = 1'b1;
      tick();

      // Basic apply.
      cmd(8'h50, 8'h32);
      chk("t1_pending", 8'(pending), 8'h01);
      chk("t1_hold", 8'(pattern), 8'h04);
      ticks(3);
      frame("t1_frame", 4'h4, 4'h2);

      // Error reply, and junk in IDLE.
      send(8'h50);
      exp_q.push_back(8'h3F);
      send(8'h47);
      ticks(2);
      chk("t2_pattern", 8'(pattern), 8'h02);
      chk("t2_pending", 8'(pending), 8'h00);
      send(8'h78);
      ticks(3);

      // Busy transmitter holds the reply.
      tx_active = 1'b1;
      send(8'h50);
      send(8'h61);
      send(8'h0D);
      ticks(5);
      exp_q.push_back(8'h4B);
      tx_active = 1'b0;
      ticks(3);
      frame("t3a_frame", 4'h2, 4'hA);

      // Overwrite: only the latest unsent reply goes out.
      tx_active = 1'b1;
      send(8'h50);
      send(8'h62);
      send(8'h0D);
      send(8'h50);
      send(8'h51);
      ticks(3);
      exp_q.push_back(8'h3F);
      tx_active = 1'b0;
      ticks(3);
      frame("t3b_frame", 4'hA, 4'hB);

      // 15 idle clocks mid-command is still within the limit.
      send(8'h50);
      ticks(15);
      send(8'h33);
      exp_q.push_back(8'h4B);
      send(8'h0D);
      ticks(2);
      frame("t4a_frame", 4'hB, 4'h3);

      // 16 idle clocks abandons the command.
      send(8'h50);
      ticks(16);
      send(8'h34);
      send(8'h0D);
      ticks(3);
      chk("t4b_pending", 8'(pending), 8'h00);
      frame("t4b_frame", 4'h3, 4'h3);

      // CR on the boundary cycle: older pending applies now, new one next frame.
      cmd(8'h50, 8'h31);
      send(8'h50);
      send(8'h35);
      exp_q.push_back(8'h4B);
      rx_dv   = 1'b1;
      rx_byte = 8'h0D;
      vsync   = 1'b1;
      tick();
      rx_dv   = 1'b0;
      chk("t5_old_applied", 8'(pattern), 8'h01);
      chk("t5_still_pending", 8'(pending), 8'h01);
      vsync = 1'b0;
      ticks(2);
      frame("t5_frame", 4'h1, 4'h5);

      // Last wins, lowercase prefix.
      cmd(8'h50, 8'h31);
      cmd(8'h70, 8'h37);
      chk("t6_pending", 8'(pending), 8'h01);
      ticks(2);
      frame("t6_frame", 4'h5, 4'h7);

      cmd(8'h50, 8'h45);
      ticks(2);
      frame("t7_frame", 4'h7, 4'hE);

      // Reset with a pending pattern and a half-finished command.
      cmd(8'h50, 8'h36);
      send(8'h50);
      send(8'h39);
      rst_n = 1'b0;
      ticks(2);
      rst_n = 1'b1;
      chk("t8_pattern", 8'(pattern), 8'h04);
      chk("t8_pending", 8'(pending), 8'h00);
      tick();
      send(8'h0D);
      ticks(3);
      frame("t8_frame", 4'h4, 4'h4);

      ticks(5);
      chk("reply_queue_drained", 8'(exp_q.size()), 8'h00);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/vga_pattern_cmd.md
VGA_PATTERN_CMD -- requirements
Module: vga_pattern_cmd

Interface
REQ-001 Parameter DEFAULT_PATTERN, 4'h4, pattern driven after reset.
REQ-002 Parameter TIMEOUT_CLKS, 25_000_000, idle clocks mid-command before the parser abandons it.
REQ-003 i_Clk  in  1  pixel/system clock; all logic SHALL be on its rising edge.
REQ-004 i_Rst_L  in  1  reset; synchronous, active-low.
REQ-005 i_RX_DV  in  1  single-cycle strobe; i_RX_Byte valid.
REQ-006 i_RX_Byte  in  8  received UART byte.
REQ-007 i_VSync  in  1  raw VSync from the sync pulse generator; high during active rows.
REQ-008 i_TX_Active  in  1  UART transmitter busy.
REQ-009 o_Pattern  out  4  pattern select to the test pattern generator.
REQ-010 o_Pending  out  1  accepted pattern waiting for frame boundary.
REQ-011 o_TX_DV  out  1  single-cycle reply strobe to the UART transmitter.
REQ-012 o_TX_Byte  out  8  reply byte.

Function
REQ-013 The command format SHALL be 'P' (0x50) or 'p' (0x70), then one hex digit (0-9, A-F, a-f), then CR (0x0D).
REQ-014 Parser states SHALL be IDLE, GOT_P and GOT_DIGIT, with bytes consumed only on i_RX_DV=1.
REQ-015 IDLE transitions:
- 'P'/'p' -> GOT_P.
- Any other byte -> ignored, stay IDLE, no reply.
REQ-016 GOT_P transitions:
- Hex digit -> latch its 4-bit value, go to GOT_DIGIT.
- Any other byte -> queue reply '?' (0x3F), go to IDLE.
REQ-017 GOT_DIGIT transitions:
- CR -> set pending pattern = latched digit, o_Pending=1, queue reply 'K' (0x4B), go to IDLE.
- Any other byte -> queue '?', go to IDLE.
REQ-018 Timeout counter:
- Clears on every i_RX_DV and whenever the state is IDLE.
- In GOT_P or GOT_DIGIT, reaching TIMEOUT_CLKS-1 without a byte returns to IDLE silently: no reply, pending untouched.
REQ-019 The frame boundary SHALL be the cycle where i_VSync=1 and its registered previous value=0.
REQ-020 On a frame boundary with o_Pending=1, o_Pattern SHALL take the pending value and o_Pending SHALL clear, both visible the next cycle.
- With o_Pending=0, o_Pattern holds.
REQ-021 Latency:
- CR accepted on cycle N -> o_Pending=1 from N+1.
- o_Pattern changes only at boundary E+1, E > N.
REQ-022 A CR accepted on the same cycle as a boundary SHALL NOT apply at that boundary.
- It sets pending for the next boundary.
- That same cycle's older pending value applies now.
REQ-023 Multiple accepted commands before one boundary: last wins; o_Pending stays 1.
REQ-024 The reply buffer SHALL be one entry deep; a new reply overwrites an unsent one.
REQ-025 A reply SHALL be emitted as o_TX_DV=1 for exactly one cycle, only in a cycle where i_TX_Active=0.
- The buffer empties on that cycle.
- o_TX_Byte holds its value until the next reply.
REQ-026 A reply queued on cycle N with i_TX_Active=0 SHALL strobe on N+1.
- While i_TX_Active=1 the reply waits indefinitely.
REQ-027 o_Pattern SHALL never change except per REQ-020 or reset.

Reset
REQ-028 While i_Rst_L=0 at a clock edge, the block SHALL hold:
- o_Pattern=DEFAULT_PATTERN; o_Pending=0.
- o_TX_DV=0; o_TX_Byte=8'h00.
- State=IDLE; timeout counter=0; reply buffer empty.
- Previous-VSync register=1, so no boundary on the first cycle after reset.
REQ-029 Reset mid-command or with a pending pattern SHALL discard both; the first byte after release is parsed from IDLE.

Verification
REQ-030 Command apply:
- Stimulus: bytes 'P','2',CR with i_VSync=0, then an i_VSync 0->1 edge at cycle E.
- Response: o_Pending=1 after CR; o_Pattern=4 until E, =2 at E+1; single 'K' strobe.
REQ-031 Error reply:
- Stimulus: 'P','G' -> response: '?' strobe, o_Pattern unchanged.
- Stimulus: 'x' in IDLE -> response: no reply.
REQ-032 Busy transmitter and overwrite:
- Stimulus: i_TX_Active=1 while 'P','a',CR completes.
- Response: no strobe until i_TX_Active=0, then exactly one 'K'; pattern 0xA applied at next boundary.
- Stimulus: a second command finishes while the first reply is still unsent.
- Response: only the latest reply is sent.
REQ-033 Timeout (TIMEOUT_CLKS=16):
- Stimulus: 'P', 16 idle clocks, then '3',CR.
- Response: parser back in IDLE, '3' and CR ignored, no reply, o_Pending=0.
REQ-034 Boundary collision and last-wins:
- Stimulus: CR of 'P','5' lands on the boundary cycle.
- Response: o_Pattern unchanged there; becomes 5 at the following boundary.
- Stimulus: 'P1'CR then 'P7'CR before one boundary.
- Response: o_Pattern=7.
REQ-035 Reset mid-operation:
- Stimulus: assert i_Rst_L=0 after 'P','9' and with pending=6.
- Response: o_Pattern=4, o_Pending=0; a subsequent lone CR gives no reply.
